uart_frame_parser: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/frame_buffer.sv | 35 +++
 rtl/uart_frame_parser.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser.
//   parser_state_e : frame delineation states
//   err_code_e     : drop reason reported with err_out
//   SYNC_WORD_DEFAULT : default frame start marker
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    EMIT
  } parser_state_e;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

endpackage

// File: rtl/frame_buffer.sv
// Payload store for one frame: single-port register array with synchronous
// write and registered read. The read register is cleared by reset so the
// parser's data output reads zero after reset.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset (read register only)
//   we, re         : write enable, read enable (share addr)
//   addr           : word address
//   wdata          : write data
//   rdata          : registered read data
module frame_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver. Delineates SYNC, LEN, LEN payload
// words, CHECKSUM (sum of LEN and payload, mod 2^WIDTH), buffers the payload
// and streams accepted frames out on valid/ready with a last marker.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   valid_in, data_in     : one-cycle received word strobe and word
//   data_out, valid_out   : registered payload stream
//   ready_in, last_out    : consumer ready, final-word marker
//   frame_ok_out          : pulse when a frame is accepted
//   err_out, err_code_out : pulse and reason when a frame is dropped
//
// state   | meaning
// HUNT    | waiting for SYNC_WORD, other words ignored
// LEN     | expecting the length word
// PAYLOAD | storing payload words into the buffer
// CHECK   | expecting the checksum word
// EMIT    | streaming the buffered payload to the consumer
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               MAX_PAYLOAD    = 32,
  parameter logic [WIDTH-1:0] SYNC_WORD      = WIDTH'(SYNC_WORD_DEFAULT),
  parameter int               TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             last_out,
  output logic             frame_ok_out,
  output logic             err_out,
  output logic [1:0]       err_code_out
);

  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  // Down-counter: loaded on each strobe, timeout fires when it sits at zero,
  // which is exactly TIMEOUT_CYCLES clocks after the strobe edge.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  parser_state_e    state_q, state_d;
  logic [LW-1:0]    len_q, idx_q;
  logic [WIDTH-1:0] sum_q;
  logic [TW-1:0]    timer_q;

  logic      valid_q, valid_d;
  logic      last_q, last_d;
  logic      frame_ok_q, frame_ok_d;
  logic      err_q, err_d;
  err_code_e err_code_q, err_code_d;

  logic          buf_we, buf_re;
  logic [AW-1:0] buf_addr;

  logic len_ok, csum_ok, is_last_word, emit_next_last, timer_done;

  assign len_ok         = (data_in != '0) && (data_in <= WIDTH'(MAX_PAYLOAD));
  assign csum_ok        = (data_in == sum_q);
  assign is_last_word   = (idx_q == len_q - LW'(1));
  assign emit_next_last = ((idx_q + LW'(1)) == (len_q - LW'(1)));
  assign timer_done     = (timer_q == '0);

  // state register and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= HUNT;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_LEN;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // next state; a strobe always takes priority over an expiring timer
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (valid_in && data_in == SYNC_WORD) state_d = LEN;
      LEN: begin
        if (valid_in)        state_d = len_ok ? PAYLOAD : HUNT;
        else if (timer_done) state_d = HUNT;
      end
      PAYLOAD: begin
        if (valid_in) begin
          if (is_last_word) state_d = CHECK;
        end else if (timer_done) begin
          state_d = HUNT;
        end
      end
      CHECK: begin
        if (valid_in)        state_d = csum_ok ? EMIT : HUNT;
        else if (timer_done) state_d = HUNT;
      end
      EMIT:    if (ready_in && last_q) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // next values of registered outputs and buffer controls
  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    frame_ok_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_LEN;
    buf_we     = 1'b0;
    buf_re     = 1'b0;
    buf_addr   = AW'(idx_q);
    case (state_q)
      LEN: begin
        if (valid_in && !len_ok) begin
          err_d      = 1'b1;
          err_code_d = ERR_LEN;
        end else if (!valid_in && timer_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        if (valid_in) begin
          buf_we = 1'b1;
        end else if (timer_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (valid_in) begin
          if (csum_ok) begin
            // word 0 is read now so it is on data_out with frame_ok_out
            frame_ok_d = 1'b1;
            valid_d    = 1'b1;
            last_d     = (len_q == LW'(1));
            buf_re     = 1'b1;
            buf_addr   = '0;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end else if (timer_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      EMIT: begin
        if (valid_in) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (ready_in) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            buf_re   = 1'b1;
            buf_addr = AW'(idx_q + LW'(1));
            last_d   = emit_next_last;
          end
        end
      end
      default: ;
    endcase
  end

  // length, index, checksum and timer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        HUNT: if (valid_in && data_in == SYNC_WORD) timer_q <= TIMER_LOAD;
        LEN: begin
          if (valid_in) begin
            if (len_ok) begin
              len_q <= LW'(data_in);
              sum_q <= data_in;
              idx_q <= '0;
            end
            timer_q <= TIMER_LOAD;
          end else if (!timer_done) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        PAYLOAD: begin
          if (valid_in) begin
            sum_q   <= sum_q + data_in;
            timer_q <= TIMER_LOAD;
            if (!is_last_word) idx_q <= idx_q + LW'(1);
          end else if (!timer_done) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        CHECK: begin
          if (valid_in)           idx_q   <= '0;
          else if (!timer_done)   timer_q <= timer_q - TW'(1);
        end
        EMIT: if (ready_in && !last_q) idx_q <= idx_q + LW'(1);
        default: ;
      endcase
    end
  end

  frame_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_frame_buffer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we     (buf_we),
    .re     (buf_re),
    .addr   (buf_addr),
    .wdata  (data_in),
    .rdata  (data_out)
  );

  assign valid_out    = valid_q;
  assign last_out     = last_q;
  assign frame_ok_out = frame_ok_q;
  assign err_out      = err_q;
  assign err_code_out = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam logic [15:0] SYNC = 16'hA55A;
  localparam int          TMO  = 100;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        ready_in = 1'b0;
  logic [15:0] data_out;
  logic        valid_out, last_out, frame_ok_out, err_out;
  logic [1:0]  err_code_out;

  int checks = 0;
  int errors = 0;

  logic [16:0] got_w[$];
  logic [1:0]  got_err[$];
  int          got_ok = 0;
  logic [16:0] exp_w[$];
  logic [1:0]  exp_err[$];
  int          exp_ok;

  uart_frame_parser #(
    .WIDTH          (16),
    .MAX_PAYLOAD    (32),
    .SYNC_WORD      (16'hA55A),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .last_out     (last_out),
    .frame_ok_out (frame_ok_out),
    .err_out      (err_out),
    .err_code_out (err_code_out)
  );

  always #5 clk_in = ~clk_in;

  // observation: handshakes, accepts and drops as seen by the next edge
  always @(negedge clk_in) begin
    if (valid_out && ready_in) got_w.push_back({last_out, data_out});
    if (frame_ok_out) got_ok++;
    if (err_out) got_err.push_back(err_code_out);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic clear_mon();
    got_w.delete();
    got_err.delete();
    got_ok = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle(3);
    checks++;
    if ({valid_out, last_out, frame_ok_out, err_out, err_code_out, data_out} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got v%b l%b ok%b e%b c%0d d%h want all 0",
               valid_out, last_out, frame_ok_out, err_out, err_code_out, data_out);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    clear_mon();
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0003);
    send_word(16'h0001); send_word(16'h0002); send_word(16'h0003);
    checks++;
    if (frame_ok_out !== 1'b0) begin
      errors++; $display("FAIL good_early_ok got %b want 0", frame_ok_out);
    end
    send_word(16'h0009);
    checks++;
    if ({frame_ok_out, valid_out, last_out, data_out} !== {3'b110, 16'h0001}) begin
      errors++;
      $display("FAIL good_word0 got ok%b v%b l%b d%h want ok1 v1 l0 d0001",
               frame_ok_out, valid_out, last_out, data_out);
    end
    tick();
    checks++;
    if ({frame_ok_out, valid_out, last_out, data_out} !== {3'b010, 16'h0002}) begin
      errors++;
      $display("FAIL good_word1 got ok%b v%b l%b d%h want ok0 v1 l0 d0002",
               frame_ok_out, valid_out, last_out, data_out);
    end
    tick();
    checks++;
    if ({valid_out, last_out, data_out} !== {2'b11, 16'h0003}) begin
      errors++;
      $display("FAIL good_word2 got v%b l%b d%h want v1 l1 d0003", valid_out, last_out, data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL good_end_valid got %b want 0", valid_out);
    end
    idle(2);
    checks++;
    if (got_ok != 1 || got_err.size() != 0 || got_w.size() != 3) begin
      errors++;
      $display("FAIL good_counts got ok=%0d err=%0d words=%0d want 1 0 3",
               got_ok, got_err.size(), got_w.size());
    end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0003);
    send_word(16'h0001); send_word(16'h0002); send_word(16'h0003);
    send_word(16'h0008);
    checks++;
    if ({err_out, err_code_out, valid_out, frame_ok_out} !== 5'b10100) begin
      errors++;
      $display("FAIL csum_err got e%b c%0d v%b ok%b want e1 c1 v0 ok0",
               err_out, err_code_out, valid_out, frame_ok_out);
    end
    idle(3);
    send_word(SYNC); send_word(16'h0002);
    send_word(16'h0005); send_word(16'h0006); send_word(16'h000D);
    checks++;
    if ({frame_ok_out, valid_out, data_out} !== {2'b11, 16'h0005}) begin
      errors++;
      $display("FAIL csum_recover got ok%b v%b d%h want ok1 v1 d0005", frame_ok_out, valid_out, data_out);
    end
    idle(4);
    checks++;
    if (got_w.size() != 2 || got_w[0] !== {1'b0, 16'h0005} || got_w[1] !== {1'b1, 16'h0006}) begin
      errors++;
      $display("FAIL csum_recover_words got n=%0d want 2 words 0005,0006(last)", got_w.size());
    end
  endtask

  task automatic test_bad_length();
    clear_mon();
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0000);
    checks++;
    if ({err_out, err_code_out} !== 3'b100) begin
      errors++; $display("FAIL len_zero got e%b c%0d want e1 c0", err_out, err_code_out);
    end
    tick();
    send_word(SYNC); send_word(16'h0021);
    checks++;
    if ({err_out, err_code_out} !== 3'b100) begin
      errors++; $display("FAIL len_33 got e%b c%0d want e1 c0", err_out, err_code_out);
    end
    send_word(16'h1234); send_word(16'h5678);
    idle(3);
    checks++;
    if (got_err.size() != 2 || err_out !== 1'b0) begin
      errors++; $display("FAIL junk_ignored got errs=%0d want 2", got_err.size());
    end
    send_word(SYNC); send_word(16'h0001); send_word(16'h0007); send_word(16'h0008);
    checks++;
    if ({frame_ok_out, last_out, data_out} !== {2'b11, 16'h0007}) begin
      errors++;
      $display("FAIL len_max1_frame got ok%b l%b d%h want ok1 l1 d0007", frame_ok_out, last_out, data_out);
    end
    idle(3);
  endtask

  task automatic test_timeout();
    int cnt;
    clear_mon();
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0002); send_word(16'h0011);
    cnt = 0;
    while (err_out !== 1'b1 && cnt < 3 * TMO) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != TMO || err_code_out !== 2'd2) begin
      errors++;
      $display("FAIL timeout_cycles got %0d cycles code %0d want %0d cycles code 2", cnt, err_code_out, TMO);
    end
    idle(2);
    send_word(SYNC); send_word(16'h0001); send_word(16'h0004); send_word(16'h0005);
    checks++;
    if (frame_ok_out !== 1'b1 || got_err.size() != 1) begin
      errors++;
      $display("FAIL timeout_to_hunt got ok%b errs=%0d want ok1 errs=1", frame_ok_out, got_err.size());
    end
    idle(3);
  endtask

  task automatic test_stall_overrun();
    clear_mon();
    ready_in = 1'b0;
    send_word(SYNC); send_word(16'h0002);
    send_word(16'h0007); send_word(16'h0008); send_word(16'h0011);
    checks++;
    if ({frame_ok_out, valid_out, last_out, data_out} !== {3'b110, 16'h0007}) begin
      errors++;
      $display("FAIL stall_first got ok%b v%b l%b d%h want ok1 v1 l0 d0007",
               frame_ok_out, valid_out, last_out, data_out);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        data_in  = 16'h1234;
        valid_in = 1'b1;
      end
      tick();
      valid_in = 1'b0;
      checks++;
      if ({valid_out, last_out, data_out} !== {2'b10, 16'h0007}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v%b l%b d%h want v1 l0 d0007", i, valid_out, last_out, data_out);
      end
      checks++;
      if (err_out !== (i == 3) || (i == 3 && err_code_out !== 2'd3)) begin
        errors++;
        $display("FAIL stall_overrun[%0d] got e%b c%0d want e%0d c3", i, err_out, err_code_out, (i == 3));
      end
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if ({valid_out, last_out, data_out} !== {2'b11, 16'h0008}) begin
      errors++;
      $display("FAIL stall_second got v%b l%b d%h want v1 l1 d0008", valid_out, last_out, data_out);
    end
    tick();
    idle(2);
    checks++;
    if (valid_out !== 1'b0 || got_w.size() != 2 || got_w[0] !== {1'b0, 16'h0007}
        || got_w[1] !== {1'b1, 16'h0008}) begin
      errors++;
      $display("FAIL stall_delivered got v%b n=%0d want v0 n=2", valid_out, got_w.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0004); send_word(16'h0001); send_word(16'h0002);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++;
    if ({valid_out, last_out, frame_ok_out, err_out, err_code_out, data_out} !== 22'd0) begin
      errors++; $display("FAIL rst_payload got v%b d%h e%b want all 0", valid_out, data_out, err_out);
    end
    ready_in = 1'b0;
    send_word(SYNC); send_word(16'h0001); send_word(16'h0042); send_word(16'h0043);
    checks++;
    if ({valid_out, data_out} !== {1'b1, 16'h0042}) begin
      errors++; $display("FAIL rst_pre_emit got v%b d%h want v1 d0042", valid_out, data_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++;
    if ({valid_out, last_out, frame_ok_out, err_out, err_code_out, data_out} !== 22'd0) begin
      errors++; $display("FAIL rst_emit got v%b l%b d%h want all 0", valid_out, last_out, data_out);
    end
    ready_in = 1'b1;
    send_word(SYNC); send_word(16'h0001); send_word(16'hFFFF); send_word(16'h0000);
    checks++;
    if ({frame_ok_out, valid_out, last_out, data_out} !== {3'b111, 16'hFFFF}) begin
      errors++;
      $display("FAIL rst_wrap_frame got ok%b v%b l%b d%h want ok1 v1 l1 dffff",
               frame_ok_out, valid_out, last_out, data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || got_err.size() != 0) begin
      errors++; $display("FAIL rst_wrap_end got v%b errs=%0d want v0 errs=0", valid_out, got_err.size());
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [15:0] pl[$];
    logic [15:0] w, len, csum;
    int kind, n, cnt;
    clear_mon();
    exp_w.delete();
    exp_err.delete();
    exp_ok   = 0;
    ready_in = 1'b0;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        w = 16'($urandom);
        if (w == SYNC) w = ~w;
        send_word(w);
        idle($urandom_range(0, 3));
      end
      kind = $urandom_range(0, 3);
      send_word(SYNC);
      idle($urandom_range(0, 3));
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(33, 65535));
        send_word(len);
        exp_err.push_back(2'd0);
      end else begin
        len  = 16'($urandom_range(1, 32));
        csum = len;
        pl.delete();
        send_word(len);
        for (int j = 0; j < int'(len); j++) begin
          idle($urandom_range(0, 3));
          w = 16'($urandom);
          pl.push_back(w);
          csum = csum + w;
          send_word(w);
        end
        idle($urandom_range(0, 3));
        if (kind == 1) begin
          send_word(csum + 16'($urandom_range(1, 65535)));
          exp_err.push_back(2'd1);
        end else begin
          send_word(csum);
          exp_ok++;
          for (int j = 0; j < int'(len); j++) exp_w.push_back({(j == int'(len) - 1), pl[j]});
          cnt = 0;
          while (valid_out === 1'b1 && cnt < 1000) begin
            ready_in = 1'($urandom_range(0, 1));
            tick();
            cnt++;
          end
          ready_in = 1'b0;
          if (cnt >= 1000) begin
            checks++;
            errors++;
            $display("FAIL rand_emit_stuck frame %0d got valid_out held want drained", f);
          end
        end
      end
      idle(1);
    end
    idle(3);
    checks++;
    if (got_ok != exp_ok) begin
      errors++; $display("FAIL rand_ok_count got %0d want %0d", got_ok, exp_ok);
    end
    checks++;
    if (got_err.size() != exp_err.size()) begin
      errors++; $display("FAIL rand_err_count got %0d want %0d", got_err.size(), exp_err.size());
    end
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++) begin
      checks++;
      if (got_err[i] !== exp_err[i]) begin
        errors++; $display("FAIL rand_err_code[%0d] got %0d want %0d", i, got_err[i], exp_err[i]);
      end
    end
    checks++;
    if (got_w.size() != exp_w.size()) begin
      errors++; $display("FAIL rand_word_count got %0d want %0d", got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL rand_word[%0d] got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_stall_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
